// File: rtl/mul8_tree_pkg.sv
// Shared types, column layout of the 8x8 partial-product bus and the packing function
// used by the compressor-tree scheduler.
package mul8_tree_pkg;

    localparam int ID_W = 2;

    typedef logic [ID_W-1:0] req_id_t;

    localparam int COL_W   [15] = '{1, 2, 3, 4, 5, 6, 7, 8, 7, 6, 5, 4, 3, 2, 1};
    localparam int COL_OFS [15] = '{0, 1, 3, 6, 10, 15, 21, 28, 36, 43, 49, 54, 58, 61, 63};

    // Column k carries a[i]&b[k-i] for every legal i, lowest i first.
    function automatic logic [63:0] pp_pack(input logic [7:0] a, input logic [7:0] b);
        logic [63:0] pp;
        int          lo;
        pp = 64'd0;
        for (int k = 0; k < 15; k++) begin
            lo = (k > 7) ? (k - 7) : 0;
            for (int n = 0; n < COL_W[k]; n++) begin
                pp[COL_OFS[k] + n] = a[lo + n] & b[k - lo - n];
            end
        end
        return pp;
    endfunction

endpackage

// File: rtl/mul8_tree_sched_rr_arbiter.sv
// Round-robin arbiter: first set request at or above ptr (wrapping) wins while en is high.
module rr_arbiter
    import mul8_tree_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               any
);

    int   pos_s;
    logic hit_s;

    // Scan offsets from farthest to nearest so the nearest requester to ptr is written last.
    always_comb begin
        gnt_idx = '0;
        any     = 1'b0;
        pos_s   = 0;
        hit_s   = 1'b0;
        for (int o = NUM_REQ - 1; o >= 0; o--) begin
            pos_s   = int'(ptr) + o;
            pos_s   = (pos_s >= NUM_REQ) ? (pos_s - NUM_REQ) : pos_s;
            hit_s   = en & req[pos_s];
            gnt_idx = hit_s ? IDX_W'(pos_s) : gnt_idx;
            any     = any | hit_s;
        end
        gnt = any ? (NUM_REQ'(1) << gnt_idx) : '0;
    end

endmodule

// File: rtl/mul8_tree_sched.sv
// Feeds one pipelined 8x8 compressor tree from NUM_REQ requesters and returns each
// product to its owner; the whole pipeline freezes under output backpressure.
module mul8_tree_sched
    import mul8_tree_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int STAGES  = 8,
    parameter int ID_W    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*8-1:0] req_a,
    input  logic [NUM_REQ*8-1:0] req_b,
    output logic [63:0]          pp_bits,
    output logic                 tree_en,
    input  logic [15:0]          tree_sum,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [15:0]          rsp_prod,
    output logic [3:0]           inflight
);

    logic [NUM_REQ-1:0] gnt_s;
    logic [ID_W-1:0]    gnt_idx_s;
    logic               any_s;
    logic               tree_en_s;
    logic               rsp_hs_s;
    logic [7:0]         a_s;
    logic [7:0]         b_s;
    logic [ID_W-1:0]    rr_next_s;

    logic [STAGES-1:0]  vld_r;
    logic [ID_W-1:0]    id_r [STAGES];
    logic [ID_W-1:0]    rr_ptr_r;
    logic [63:0]        pp_bits_r;
    logic [3:0]         inflight_r;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (ID_W)
    ) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr_r),
        .en      (tree_en_s),
        .gnt     (gnt_s),
        .gnt_idx (gnt_idx_s),
        .any     (any_s)
    );

    // Stall decode, operand select for the granted requester and next pointer.
    always_comb begin
        tree_en_s = ~(vld_r[STAGES-1] & ~rsp_ready);
        rsp_hs_s  = vld_r[STAGES-1] & rsp_ready;
        a_s       = req_a[int'(gnt_idx_s) * 8 +: 8];
        b_s       = req_b[int'(gnt_idx_s) * 8 +: 8];
        rr_next_s = (int'(gnt_idx_s) == NUM_REQ - 1) ? '0 : (gnt_idx_s + 1'b1);
    end

    // Valid/owner shift pipe; a stall holds every slot including bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_r <= '0;
            for (int k = 0; k < STAGES; k++) id_r[k] <= '0;
        end else if (tree_en_s) begin
            vld_r <= {vld_r[STAGES-2:0], any_s};
            id_r[0] <= gnt_idx_s;
            for (int k = 1; k < STAGES; k++) id_r[k] <= id_r[k-1];
        end else begin
            vld_r <= vld_r;
            for (int k = 0; k < STAGES; k++) id_r[k] <= id_r[k];
        end
    end

    // Operand capture and pointer advance; the bus holds on idle cycles to avoid toggling.
    always_ff @(posedge clk) begin
        if (rst) begin
            pp_bits_r <= 64'd0;
            rr_ptr_r  <= '0;
        end else if (any_s) begin
            pp_bits_r <= pp_pack(a_s, b_s);
            rr_ptr_r  <= rr_next_s;
        end else begin
            pp_bits_r <= pp_bits_r;
            rr_ptr_r  <= rr_ptr_r;
        end
    end

    // Occupancy: grants in, response handshakes out.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_r <= 4'd0;
        end else begin
            inflight_r <= inflight_r + {3'b000, any_s} - {3'b000, rsp_hs_s};
        end
    end

    assign req_ready = gnt_s;
    assign tree_en   = tree_en_s;
    assign pp_bits   = pp_bits_r;
    assign rsp_valid = vld_r[STAGES-1];
    assign rsp_id    = id_r[STAGES-1];
    assign rsp_prod  = tree_sum;
    assign inflight  = inflight_r;

endmodule

// File: tb/tb_mul8_tree_sched.sv
// Scoreboard bench for mul8_tree_sched with a behavioural enable-gated tree model.
module tb_mul8_tree_sched;
    import mul8_tree_pkg::*;

    localparam int NR = 4;
    localparam int ST = 8;

    typedef struct packed {
        req_id_t     id;
        logic [15:0] prod;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NR-1:0]   req_valid = '0;
    logic [NR-1:0]   req_ready;
    logic [NR*8-1:0] req_a = '0;
    logic [NR*8-1:0] req_b = '0;
    logic [63:0]     pp_bits;
    logic            tree_en;
    logic [15:0]     tree_sum;
    logic            rsp_valid;
    logic            rsp_ready = 1'b1;
    logic [ID_W-1:0] rsp_id;
    logic [15:0]     rsp_prod;
    logic [3:0]      inflight;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_push   = 0;
    int          n_rsp    = 0;
    logic [15:0] pp_sum;
    logic [15:0] tree_pipe [ST-1];

    mul8_tree_sched #(.NUM_REQ(NR), .STAGES(ST), .ID_W(ID_W)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .pp_bits(pp_bits), .tree_en(tree_en),
        .tree_sum(tree_sum), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_prod(rsp_prod), .inflight(inflight)
    );

    always #5 clk = ~clk;

    // Tree model: weight every pp bit by its column, then delay through ST-1 gated stages.
    always_comb begin
        int ofs;
        ofs    = 0;
        pp_sum = 16'd0;
        for (int k = 0; k < 15; k++) begin
            for (int i = 0; i < 8; i++) begin
                if (k - i >= 0 && k - i <= 7) begin
                    if (pp_bits[ofs]) pp_sum = pp_sum + (16'd1 << k);
                    ofs++;
                end
            end
        end
    end

    initial for (int s = 0; s < ST - 1; s++) tree_pipe[s] = 16'd0;

    always @(posedge clk) begin
        if (tree_en) begin
            tree_pipe[0] <= pp_sum;
            for (int s = 1; s < ST - 1; s++) tree_pipe[s] <= tree_pipe[s-1];
        end
    end

    assign tree_sum = tree_pipe[ST-2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Scoreboard: push on request handshake, pop and compare on response handshake.
    always @(posedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (rsp_valid && rsp_ready) begin
                n_rsp++;
                if (sb.size() == 0) begin
                    check_eq("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check_eq("sb_id", 32'(rsp_id), 32'(e.id));
                    check_eq("sb_prod", 32'(rsp_prod), 32'(e.prod));
                end
            end
            for (int i = 0; i < NR; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    logic [7:0] a;
                    logic [7:0] b;
                    a = req_a[8*i +: 8];
                    b = req_b[8*i +: 8];
                    sb.push_back('{id: req_id_t'(i), prod: 16'(a) * 16'(b)});
                    n_push++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((sb.size() != 0 || inflight != 4'd0) && n < 200) begin
            step();
            n++;
        end
        check_eq(tag, 32'(sb.size()) + 32'(inflight), 32'd0);
    endtask

    task automatic run_single(input string tag, input int idx, input logic [7:0] a,
                              input logic [7:0] b, input logic [15:0] exp, output int lat);
        req_a[8*idx +: 8] = a;
        req_b[8*idx +: 8] = b;
        req_valid         = NR'(1) << idx;
        step();
        req_valid = '0;
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            step();
            lat++;
        end
        check_eq({tag, "_prod"}, 32'(rsp_prod), 32'(exp));
        check_eq({tag, "_id"}, 32'(rsp_id), 32'(idx));
    endtask

    initial begin
        int lat;
        int cnt;
        int push0;
        int rsp0;
        logic [15:0] cap_prod;
        logic [ID_W-1:0] cap_id;
        logic [63:0] cap_pp;

        // 1: reset state and single max operand.
        do_reset();
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_req_ready", 32'(req_ready), 32'd0);
        check_eq("rst_tree_en", 32'(tree_en), 32'd1);
        check_eq("rst_inflight", 32'(inflight), 32'd0);
        check_eq("rst_pp_bits", pp_bits[31:0] | pp_bits[63:32], 32'd0);
        req_valid = 4'b0001;
        #1;
        check_eq("t1_grant", 32'(req_ready), 32'd1);
        req_valid = 4'b0000;
        run_single("t1", 0, 8'hFF, 8'hFF, 16'hFE01, lat);
        check_eq("t1_latency", 32'(lat), 32'(ST));
        step();
        check_eq("t1_inflight_end", 32'(inflight), 32'd0);

        // 2: four requesters, round-robin order and back-to-back results.
        do_reset();
        for (int i = 0; i < NR; i++) begin
            req_a[8*i +: 8] = 8'(i + 1);
            req_b[8*i +: 8] = 8'd3;
        end
        req_valid = 4'b1111;
        #1;
        for (int k = 0; k < NR; k++) begin
            check_eq("t2_grant", 32'(req_ready), 32'(1 << k));
            step();
        end
        req_valid = '0;
        cnt = 0;
        while (!rsp_valid && cnt < 40) begin
            step();
            cnt++;
        end
        for (int k = 0; k < NR; k++) begin
            check_eq("t2_b2b_valid", 32'(rsp_valid), 32'd1);
            check_eq("t2_id", 32'(rsp_id), 32'(k));
            check_eq("t2_prod", 32'(rsp_prod), 32'(3 * (k + 1)));
            step();
        end
        drain("t2_drain");

        // 3: fill the pipe under backpressure, hold, then release.
        rsp_ready = 1'b0;
        push0     = n_push;
        req_valid = 4'b1111;
        req_a     = $urandom;
        req_b     = $urandom;
        cnt = 0;
        while (tree_en && cnt < 40) begin
            step();
            req_a = $urandom;
            req_b = $urandom;
            cnt++;
        end
        check_eq("t3_inflight_full", 32'(inflight), 32'(ST));
        cap_prod = rsp_prod;
        cap_id   = rsp_id;
        cap_pp   = pp_bits;
        for (int c = 0; c < 5; c++) begin
            check_eq("t3_tree_en", 32'(tree_en), 32'd0);
            check_eq("t3_req_ready", 32'(req_ready), 32'd0);
            check_eq("t3_hold_prod", 32'(rsp_prod), 32'(cap_prod));
            check_eq("t3_hold_id", 32'(rsp_id), 32'(cap_id));
            check_eq("t3_hold_pp", pp_bits[31:0] ^ cap_pp[31:0] ^ pp_bits[63:32] ^ cap_pp[63:32], 32'd0);
            step();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        rsp0      = n_rsp;
        drain("t3_drain");
        check_eq("t3_pushes", 32'(n_push - push0), 32'(ST));
        check_eq("t3_results", 32'(n_rsp - rsp0), 32'(ST));

        // 4: pointer at 2, only req0 and req3 competing.
        do_reset();
        req_valid = 4'b0010;
        step();
        req_valid = 4'b1001;
        #1;
        check_eq("t4_grant_a", 32'(req_ready), 32'b1000);
        step();
        check_eq("t4_grant_b", 32'(req_ready), 32'b0001);
        step();
        check_eq("t4_grant_c", 32'(req_ready), 32'b1000);
        step();
        req_valid = '0;
        drain("t4_drain");

        // 5: corner operands exercising the ends of the column layout.
        run_single("t5_zero", 2, 8'h00, 8'hA5, 16'h0000, lat);
        run_single("t5_msb", 1, 8'h80, 8'h80, 16'h4000, lat);
        run_single("t5_lsb", 3, 8'h01, 8'h01, 16'h0001, lat);
        drain("t5_drain");

        // 6: reset with five operations in flight.
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) step();
        req_valid = '0;
        check_eq("t6_inflight_pre", 32'(inflight), 32'd5);
        do_reset();
        check_eq("t6_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("t6_inflight", 32'(inflight), 32'd0);
        req_valid = 4'b1111;
        #1;
        check_eq("t6_ptr_zero", 32'(req_ready), 32'b0001);
        req_valid = '0;
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (rsp_valid) cnt++;
        end
        check_eq("t6_no_stale", 32'(cnt), 32'd0);
        check_eq("end_sb_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
